// File: rtl/mrd_pkg.sv
// mrd_pkg: shared user count, FSM state type and datapath width helpers
// for the residual generator (residual_gen and its dot16 sub-module).
package mrd_pkg;

   localparam int USERS = 16;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   // PROD_W: one h*x product
   function automatic int prod_w(input int w);
      return 2 * w;
   endfunction

   // SUM_W: sum of USERS products, 4 guard bits
   function automatic int sum_w(input int w);
      return 2 * w + 4;
   endfunction

   // RES_W: residual, one more bit for the subtraction
   function automatic int res_w(input int w);
      return 2 * w + 5;
   endfunction

   // EN_W: residual energy accumulator
   function automatic int en_w(input int w);
      return 2 * w + 9;
   endfunction

endpackage

// File: rtl/residual_gen_dot16.sv
// dot16: 16 signed multipliers (registered, stage 1) feeding an adder tree
// whose result is registered by the parent (stage 2). i_adv freezes the stage.
module dot16
   import mrd_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_adv,
   input  logic                      i_valid,
   input  logic [USERS*WIDTH-1:0]    i_x,
   input  logic [USERS*WIDTH-1:0]    i_h,
   input  logic [WIDTH-1:0]          i_y,
   output logic                      o_valid,
   output logic [WIDTH-1:0]          o_y,
   output logic signed [2*WIDTH+3:0] o_sum
);

   localparam int PROD_W = prod_w(WIDTH);
   localparam int SUM_W  = sum_w(WIDTH);

   logic signed [PROD_W-1:0] r_prod [USERS];
   logic                     r_valid;
   logic [WIDTH-1:0]         r_y;
   logic signed [SUM_W-1:0]  w_sum;

   // stage 1: register the 16 products together with y and the valid flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_y     <= '0;
         for (int unsigned k = 0; k < USERS; k++) begin
            r_prod[k] <= '0;
         end
      end else if (i_adv) begin
         r_valid <= i_valid;
         r_y     <= i_y;
         for (int unsigned k = 0; k < USERS; k++) begin
            r_prod[k] <= PROD_W'($signed(i_x[k*WIDTH +: WIDTH])) *
                         PROD_W'($signed(i_h[k*WIDTH +: WIDTH]));
         end
      end
   end

   // adder tree over the registered products, sign-extended to SUM_W
   always_comb begin
      w_sum = '0;
      for (int unsigned k = 0; k < USERS; k++) begin
         w_sum = w_sum + SUM_W'(r_prod[k]);
      end
   end

   assign o_valid = r_valid;
   assign o_y     = r_y;
   assign o_sum   = w_sum;

endmodule

// File: rtl/residual_gen.sv
// residual_gen: streams r = (y <<< FRAC) - H.x one antenna row per handshake.
// Optional feature macro: RESID_ENERGY_EN adds the r_energy port with a
// saturating accumulator of saturate(r >>> FRAC)^2.
module residual_gen
   import mrd_pkg::*;
#(
   parameter int DIMENSION = 256,
   parameter int WIDTH     = 8,
   parameter int FRAC      = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      start,
   input  logic [USERS*WIDTH-1:0]    x_in,
   input  logic [USERS*WIDTH-1:0]    h_row,
   input  logic [WIDTH-1:0]          y_elem,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic signed [2*WIDTH+4:0] r_elem,
   output logic                      r_valid,
   input  logic                      r_ready,
   output logic                      busy,
   output logic                      done
`ifdef RESID_ENERGY_EN
   ,
   output logic [2*WIDTH+8:0]        r_energy
`endif
);

   localparam int SUM_W = sum_w(WIDTH);
   localparam int RES_W = res_w(WIDTH);
   localparam int CNT_W = $clog2(DIMENSION + 1);
   localparam logic [CNT_W-1:0] DIM_C = CNT_W'(DIMENSION);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIMENSION - 1);

   state_t                  r_state;
   logic [CNT_W-1:0]        r_rows;
   logic [CNT_W-1:0]        r_outs;
   logic [USERS*WIDTH-1:0]  r_x;

   logic                    w_stall;
   logic                    w_adv;
   logic                    w_acc;
   logic                    w_rhs;
   logic                    w_s1_valid;
   logic [WIDTH-1:0]        w_s1_y;
   logic signed [SUM_W-1:0] w_sum;
   logic signed [RES_W-1:0] w_y_ext;

   // handshake qualifiers; a stalled output freezes every pipeline stage
   always_comb begin
      w_stall  = r_valid & ~r_ready;
      w_adv    = en & ~w_stall;
      in_ready = en && (r_state == RUN) && (r_rows < DIM_C) && !w_stall;
      w_acc    = in_valid & in_ready;
      w_rhs    = en & r_valid & r_ready;
      w_y_ext  = RES_W'($signed(w_s1_y)) <<< FRAC;
   end

   dot16 #(
      .WIDTH (WIDTH)
   ) u_dot16 (
      .clk     (clk),
      .rst     (rst),
      .i_adv   (w_adv),
      .i_valid (w_acc),
      .i_x     (r_x),
      .i_h     (h_row),
      .i_y     (y_elem),
      .o_valid (w_s1_valid),
      .o_y     (w_s1_y),
      .o_sum   (w_sum)
   );

   // stage 2: register tree sum subtracted from the aligned y
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_elem  <= '0;
      end else if (w_adv) begin
         r_valid <= w_s1_valid;
         if (w_s1_valid) begin
            r_elem <= w_y_ext - RES_W'(w_sum);
         end
      end
   end

   // control FSM: frame sequencing, row/residual counters, x capture, flags
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_rows  <= '0;
         r_outs  <= '0;
         r_x     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else if (en) begin
         case (r_state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r_x     <= x_in;
                  r_rows  <= '0;
                  r_outs  <= '0;
                  busy    <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (w_acc) begin
                  r_rows <= r_rows + CNT_W'(1);
                  if (r_rows == LAST) begin
                     r_state <= DRAIN;
                  end
               end
               if (w_rhs) begin
                  r_outs <= r_outs + CNT_W'(1);
               end
            end
            DRAIN: begin
               if (w_rhs) begin
                  r_outs <= r_outs + CNT_W'(1);
                  if (r_outs == LAST) begin
                     r_state <= DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end
               end
            end
            DONE: begin
               done    <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef RESID_ENERGY_EN
   localparam int EN_W = en_w(WIDTH);
   localparam logic signed [RES_W-1:0] RT_MAX = RES_W'((1 << (WIDTH - 1)) - 1);
   localparam logic signed [RES_W-1:0] RT_MIN = RES_W'(-(1 << (WIDTH - 1)));

   logic signed [RES_W-1:0]   w_shr;
   logic signed [WIDTH-1:0]   w_rt;
   logic signed [2*WIDTH-1:0] w_rt_x;
   logic [2*WIDTH-1:0]        w_sq;
   logic [EN_W:0]             w_esum;

   // reduce the residual to WIDTH bits and square it
   always_comb begin
      w_shr = r_elem >>> FRAC;
      if (w_shr > RT_MAX) begin
         w_rt = RT_MAX[WIDTH-1:0];
      end else if (w_shr < RT_MIN) begin
         w_rt = RT_MIN[WIDTH-1:0];
      end else begin
         w_rt = w_shr[WIDTH-1:0];
      end
      w_rt_x = (2*WIDTH)'(w_rt);
      w_sq   = w_rt_x * w_rt_x;
      w_esum = {1'b0, r_energy} + (EN_W + 1)'(w_sq);
   end

   // saturating energy accumulator, cleared by a frame start
   always_ff @(posedge clk) begin
      if (rst) begin
         r_energy <= '0;
      end else if (en) begin
         if (r_state == IDLE && start) begin
            r_energy <= '0;
         end else if (w_rhs) begin
            r_energy <= w_esum[EN_W] ? '1 : w_esum[EN_W-1:0];
         end
      end
   end
`endif

endmodule

// File: tb/tb_residual_gen.sv
`timescale 1ns/1ps
module tb_residual_gen;

   localparam int D  = 256;
   localparam int W  = 8;
   localparam int F  = 6;
   localparam int U  = 16;
   localparam int RW = 2*W + 5;
   localparam int EW = 2*W + 9;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, en, start, in_valid, in_ready, r_valid, r_ready, busy, done;
   logic [U*W-1:0] x_in, h_row;
   logic [W-1:0]   y_elem;
   logic [RW-1:0]  r_elem;
`ifdef RESID_ENERGY_EN
   logic [EW-1:0]  r_energy;
`endif

   logic           en2, start2, in_valid2, in_ready2, r_valid2, r_ready2, busy2, done2;
   logic [U*W-1:0] x_in2, h_row2;
   logic [W-1:0]   y_elem2;
   logic [RW-1:0]  r_elem2;
`ifdef RESID_ENERGY_EN
   logic [EW-1:0]  r_energy2;
`endif

   residual_gen #(.DIMENSION(D), .WIDTH(W), .FRAC(F)) dut (
      .clk(clk), .rst(rst), .en(en), .start(start), .x_in(x_in), .h_row(h_row),
      .y_elem(y_elem), .in_valid(in_valid), .in_ready(in_ready), .r_elem(r_elem),
      .r_valid(r_valid), .r_ready(r_ready), .busy(busy), .done(done)
`ifdef RESID_ENERGY_EN
      , .r_energy(r_energy)
`endif
   );

   residual_gen #(.DIMENSION(2), .WIDTH(W), .FRAC(F)) dut2 (
      .clk(clk), .rst(rst), .en(en2), .start(start2), .x_in(x_in2), .h_row(h_row2),
      .y_elem(y_elem2), .in_valid(in_valid2), .in_ready(in_ready2), .r_elem(r_elem2),
      .r_valid(r_valid2), .r_ready(r_ready2), .busy(busy2), .done(done2)
`ifdef RESID_ENERGY_EN
      , .r_energy(r_energy2)
`endif
   );

   int total = 0;
   int bad   = 0;

   logic signed [W-1:0] hm [D][U];
   logic signed [W-1:0] ym [D];
   logic signed [W-1:0] xv [U];
   longint e_energy;

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // residual of a stored row from the plain definition y*2^F - sum h*x
   function automatic longint model_r(input int row);
      longint s = 0;
      for (int k = 0; k < U; k++) s += longint'(hm[row][k]) * longint'(xv[k]);
      return longint'(ym[row]) * (longint'(1) << F) - s;
   endfunction

   function automatic longint e_step(input longint e, input longint r);
      longint rt = r >>> F;
      if (rt > 127)  rt = 127;
      if (rt < -128) rt = -128;
      e = e + rt * rt;
      if (e > (longint'(1) << EW) - 1) e = (longint'(1) << EW) - 1;
      return e;
   endfunction

   function automatic logic [U*W-1:0] pack_x();
      logic [U*W-1:0] p;
      for (int k = 0; k < U; k++) p[k*W +: W] = xv[k];
      return p;
   endfunction

   function automatic logic [U*W-1:0] pack_h(input int row);
      logic [U*W-1:0] p;
      for (int k = 0; k < U; k++) p[k*W +: W] = hm[row][k];
      return p;
   endfunction

   function automatic logic signed [W-1:0] rnd8();
      return W'(int'($urandom_range(255)) - 128);
   endfunction

   task automatic rand_all();
      for (int k = 0; k < U; k++) xv[k] = rnd8();
      for (int i = 0; i < D; i++) begin
         ym[i] = rnd8();
         for (int k = 0; k < U; k++) hm[i][k] = rnd8();
      end
   endtask

   task automatic check_reset_vals(input string nm);
      check({nm, "_in_ready"}, in_ready, 0);
      check({nm, "_r_valid"},  r_valid,  0);
      check({nm, "_r_elem"},   $signed(r_elem), 0);
      check({nm, "_busy"},     busy,     0);
      check({nm, "_done"},     done,     0);
`ifdef RESID_ENERGY_EN
      check({nm, "_energy"},   r_energy, 0);
`endif
   endtask

   task automatic run_frame(input string nm, input bit rr_pat, input bit en_gap,
                            input bit chk_lat, input bit mid_start, input int rst_row);
      int row = 0, cyc = 0, outs = 0, dones = 0, gap = 0, post = -1, c0;
      bit en_last = 1'b1;
      longint q[$];
      int qc[$];
      longint ex;
      logic prv_rv, prv_busy;
      logic [RW-1:0] prv_re;
      e_energy = 0;
      @(posedge clk); #1;
      en = 1'b1; start = 1'b1; x_in = pack_x(); in_valid = 1'b0; r_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({nm, "_busy_on"}, busy, 1);
      check({nm, "_ready_first"}, in_ready, 1);
      prv_rv = r_valid; prv_re = r_elem; prv_busy = busy;
      while (1) begin
         if (rst_row >= 0 && row == rst_row) begin
            rst = 1'b1; start = 1'b1; en = 1'b1;
            @(posedge clk); #1;
            check_reset_vals({nm, "_rst"});
            rst = 1'b0; start = 1'b0; in_valid = 1'b0;
            @(posedge clk); #1;
            check({nm, "_rst_beats_start"}, busy, 0);
            return;
         end
         r_ready  = rr_pat ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         en       = !(en_gap && row == 50 && gap < 5);
         if (!en) gap++;
         in_valid = (row < D);
         if (row < D) begin
            h_row  = pack_h(row);
            y_elem = ym[row];
         end
         start = mid_start && (row == 20);
         if (mid_start && row >= 20) x_in = ~pack_x();
         @(negedge clk);
         if (!en_last) begin
            check({nm, "_hold_rv"},   prv_rv, r_valid);
            check({nm, "_hold_re"},   $signed(prv_re), $signed(r_elem));
            check({nm, "_hold_busy"}, prv_busy, busy);
         end
         if (!en) check({nm, "_en_ready"}, in_ready, 0);
         if (r_valid && !r_ready) check({nm, "_stall_ready"}, in_ready, 0);
         if (en && in_valid && in_ready) begin
            q.push_back(model_r(row));
            qc.push_back(cyc);
            row++;
         end
         if (en && r_valid && r_ready) begin
            if (q.size() == 0) begin
               check({nm, "_extra_resid"}, 1, 0);
            end else begin
               ex = q.pop_front();
               c0 = qc.pop_front();
               check({nm, "_resid"}, $signed(r_elem), ex);
               if (chk_lat) check({nm, "_latency"}, cyc - c0, 2);
               e_energy = e_step(e_energy, ex);
               outs++;
            end
         end
         if (done) begin
            dones++;
            if (post < 0) post = 3;
         end
         prv_rv = r_valid; prv_re = r_elem; prv_busy = busy; en_last = en;
         cyc++;
         if (post == 0) break;
         if (post > 0) post--;
         if (cyc > 3000) begin
            check({nm, "_timeout"}, 0, 1);
            break;
         end
         @(posedge clk); #1;
      end
      start = 1'b0; en = 1'b1; in_valid = 1'b0;
      check({nm, "_outs"},    outs, D);
      check({nm, "_dones"},   dones, 1);
      check({nm, "_left"},    q.size(), 0);
      check({nm, "_busy_off"}, busy, 0);
`ifdef RESID_ENERGY_EN
      check({nm, "_energy"}, r_energy, e_energy);
`endif
   endtask

   initial begin
      int fr, dn2, brise, outs2, dcyc, sgn;
      logic pb;
      longint q2[$];
      longint ex2, s;

      rst = 1'b1; en = 1'b1; start = 1'b0; in_valid = 1'b0; r_ready = 1'b1;
      x_in = '0; h_row = '0; y_elem = '0;
      en2 = 1'b1; start2 = 1'b0; in_valid2 = 1'b0; r_ready2 = 1'b1;
      x_in2 = '0; h_row2 = '0; y_elem2 = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      rst = 1'b0;

      // identity: x = e3 at 1.0, h[i][3] = i mod 100, y = 0
      for (int k = 0; k < U; k++) xv[k] = 0;
      xv[3] = W'(1 << F);
      for (int i = 0; i < D; i++) begin
         ym[i] = 0;
         for (int k = 0; k < U; k++) hm[i][k] = (k == 3) ? W'(i % 100) : '0;
      end
      run_frame("ident", 0, 0, 1, 0, -1);

      // exact match: x in {-64,0,64}, small h, y chosen to cancel
      for (int k = 0; k < U; k++) xv[k] = W'((int'($urandom_range(2)) - 1) * 64);
      for (int i = 0; i < D; i++) begin
         s = 0;
         for (int k = 0; k < U; k++) begin
            hm[i][k] = W'(int'($urandom_range(14)) - 7);
            sgn = int'(xv[k]) / 64;
            s += longint'(hm[i][k]) * sgn;
         end
         ym[i] = W'(s);
      end
      run_frame("exact", 0, 0, 0, 0, -1);

      rand_all();
      run_frame("backpr", 1, 0, 0, 0, -1);

      // extremes: everything at the negative rail, y at the positive rail
      for (int k = 0; k < U; k++) xv[k] = -128;
      for (int i = 0; i < D; i++) begin
         ym[i] = 127;
         for (int k = 0; k < U; k++) hm[i][k] = -128;
      end
      run_frame("extreme", 0, 0, 0, 0, -1);

      rand_all();
      run_frame("midstart", 0, 0, 0, 1, -1);

      rand_all();
      run_frame("engap", 1, 1, 0, 0, -1);

      rand_all();
      run_frame("rstmid", 0, 0, 0, 0, 100);
      rand_all();
      run_frame("afterrst", 0, 0, 0, 0, -1);

      // two-row frames, second start in the cycle after done
      fr = 0; dn2 = 0; brise = 0; outs2 = 0; dcyc = -10; pb = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         start2 = (c == 0) || (c == dcyc + 1 && fr < 2);
         if (start2) begin
            for (int k = 0; k < U; k++) xv[k] = rnd8();
            x_in2 = pack_x();
            fr++;
         end
         for (int k = 0; k < U; k++) hm[0][k] = rnd8();
         ym[0]     = rnd8();
         h_row2    = pack_h(0);
         y_elem2   = ym[0];
         in_valid2 = 1'b1;
         @(negedge clk);
         if (in_valid2 && in_ready2) q2.push_back(model_r(0));
         if (r_valid2 && r_ready2) begin
            if (q2.size() == 0) begin
               check("min_extra", 1, 0);
            end else begin
               ex2 = q2.pop_front();
               check("min_resid", $signed(r_elem2), ex2);
               outs2++;
            end
         end
         if (done2) begin
            dn2++;
            dcyc = c;
         end
         if (busy2 && !pb) brise++;
         pb = busy2;
      end
      in_valid2 = 1'b0;
      check("min_dones", dn2, 2);
      check("min_busy_rises", brise, 2);
      check("min_outs", outs2, 4);
      check("min_left", q2.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
